// File: rtl/imu_pkg.sv
// Shared definitions for the IMU burst poller: FSM encoding and SPI frame widths.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package imu_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    ADDR     = 3'd2,
    DATA     = 3'd3,
    CS_HOLD  = 3'd4,
    CS_GAP   = 3'd5
  } state_t;

  localparam logic READ_BIT = 1'b1;
  localparam int   WORD_W   = 16;
  localparam int   ADDR_W   = 7;
  localparam int   CMD_W    = 8;   // READ_BIT + ADDR_W

endpackage

// File: rtl/imu_spi_shifter.sv
// SPI mode-3 bit engine: divides clk into SCK, shifts a command byte out MSB first
// then zeros, and samples MISO on every SCK rising edge.
// Latency: SCK falls on the edge after go; rx_vld is registered one cycle after each rising edge.
// Backpressure: none; the caller must accept every rx_vld and only pulse go while idle.
//
// Ports: clk, rst_n (async active-low); go (start a transfer), nbits (transfer length, held
// stable while active), tx_byte (command sent first); miso in; sck/mosi out; rx_vld/rx_bit
// (one strobe per sampled bit); done (combinational, high in the last cycle of the last bit).
module imu_spi_shifter
  import imu_pkg::*;
#(
  parameter int SCK_DIV = 4,
  parameter int CNT_W   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [CNT_W-1:0] nbits,
  input  logic [CMD_W-1:0] tx_byte,
  input  logic             miso,
  output logic             sck,
  output logic             mosi,
  output logic             rx_vld,
  output logic             rx_bit,
  output logic             done
);

  localparam int              DIV_W    = $clog2(SCK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);

  logic             active;
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic [CMD_W-1:0] tx_sr;
  logic             half_end;

  assign half_end = active && (div_cnt == DIV_LAST);
  // Combinational so the caller can leave its data state exactly at the end of the
  // last high half, keeping the bit phase at a whole number of SCK periods.
  assign done     = half_end && sck && (bit_cnt == nbits - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      sck     <= 1'b1;
      mosi    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_vld  <= 1'b0;
      rx_bit  <= 1'b0;
    end else begin
      rx_vld <= 1'b0;
      if (!active) begin
        if (go) begin
          active  <= 1'b1;
          sck     <= 1'b0;
          mosi    <= tx_byte[CMD_W-1];
          tx_sr   <= {tx_byte[CMD_W-2:0], 1'b0};
          div_cnt <= '0;
          bit_cnt <= '0;
        end
      end else if (half_end) begin
        div_cnt <= '0;
        if (!sck) begin
          sck    <= 1'b1;
          rx_vld <= 1'b1;
          rx_bit <= miso;
        end else if (done) begin
          // SCK parks high (mode-3 idle) and MOSI returns low.
          active <= 1'b0;
          mosi   <= 1'b0;
        end else begin
          // Falling edge: present next bit; zeros follow once the command is out.
          sck     <= 1'b0;
          bit_cnt <= bit_cnt + CNT_W'(1);
          mosi    <= tx_sr[CMD_W-1];
          tx_sr   <= {tx_sr[CMD_W-2:0], 1'b0};
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/imu_autopoll_burst.sv
// Periodic/manual SPI burst reader of NUM_REGS consecutive 16-bit IMU registers.
// Latency: cs_n falls the cycle after a trigger; word_valid 1 cycle after each word's last SCK rise.
// Backpressure: none; triggers arriving while busy are dropped and flagged on missed.
//
// Ports: clk, rst_n (async active-low); autopoll_en/poll_period (periodic trigger, period 0 = off);
// start (manual trigger); base_addr (first register); imu_sck/imu_cs_n/imu_mosi/imu_miso (SPI mode 3);
// word_valid/word_data/word_idx (received words); frame_done, missed, busy; frame_ts.
// Build option: define IMU_TIMESTAMP_EN to timestamp each frame on frame_ts (otherwise tied to 0).
module imu_autopoll_burst
  import imu_pkg::*;
#(
  parameter int NUM_REGS = 6,
  parameter int SCK_DIV  = 4,
  parameter int PERIOD_W = 24,
  parameter int IDX_W    = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                autopoll_en,
  input  logic [PERIOD_W-1:0] poll_period,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  output logic                imu_sck,
  output logic                imu_cs_n,
  output logic                imu_mosi,
  input  logic                imu_miso,
  output logic                word_valid,
  output logic [WORD_W-1:0]   word_data,
  output logic [IDX_W-1:0]    word_idx,
  output logic                frame_done,
  output logic                missed,
  output logic                busy,
  output logic [31:0]         frame_ts
);

  localparam int               NBITS    = CMD_W + WORD_W * NUM_REGS;
  localparam int               CNT_W    = $clog2(NBITS + 1);
  localparam int               TMR_W    = $clog2(SCK_DIV);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SCK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);

  state_t              state, state_nxt;
  logic [TMR_W-1:0]    tmr;
  logic [PERIOD_W-1:0] period_cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          bit_cnt;
  logic [WORD_W-2:0]   rx_sr;
  logic [IDX_W-1:0]    word_cnt;
  logic                period_on, period_trig, trig, tmr_last, frame_end;
  logic                shift_go, shift_done, rx_vld, rx_bit;

  assign period_on   = autopoll_en && (poll_period != '0);
  assign period_trig = period_on && (period_cnt == poll_period - PERIOD_W'(1));
  assign trig        = start || period_trig;   // coincident sources merge into one trigger
  assign tmr_last    = (tmr == TMR_LAST);
  assign frame_end   = (state == CS_HOLD) && tmr_last;
  assign busy        = (state != IDLE);

  imu_spi_shifter #(.SCK_DIV(SCK_DIV), .CNT_W(CNT_W)) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .go      (shift_go),
    .nbits   (CNT_W'(NBITS)),
    .tx_byte ({READ_BIT, addr_q}),
    .miso    (imu_miso),
    .sck     (imu_sck),
    .mosi    (imu_mosi),
    .rx_vld  (rx_vld),
    .rx_bit  (rx_bit),
    .done    (shift_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift_go  = 1'b0;
    case (state)
      IDLE:     if (trig) state_nxt = CS_SETUP;
      CS_SETUP: if (tmr_last) begin
                  state_nxt = ADDR;
                  shift_go  = 1'b1;
                end
      ADDR:     if (rx_vld && bit_cnt == 4'd7) state_nxt = DATA;
      DATA:     if (shift_done) state_nxt = CS_HOLD;
      CS_HOLD:  if (tmr_last) state_nxt = CS_GAP;
      CS_GAP:   if (tmr_last) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Timer for the setup/hold/gap phases; restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr        <= '0;
      period_cnt <= '0;
      imu_cs_n   <= 1'b1;
    end else begin
      if (state_nxt != state) tmr <= '0;
      else if (state == CS_SETUP || state == CS_HOLD || state == CS_GAP) tmr <= tmr + TMR_W'(1);

      // Free-runs across bursts so poll spacing does not depend on burst length.
      if (!period_on || period_trig) period_cnt <= '0;
      else                           period_cnt <= period_cnt + PERIOD_W'(1);

      imu_cs_n <= (state_nxt == IDLE) || (state_nxt == CS_GAP);
    end
  end

  // Word framing: first 8 strobes are the command echo and are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      bit_cnt    <= '0;
      rx_sr      <= '0;
      word_cnt   <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
      word_idx   <= '0;
      frame_done <= 1'b0;
      missed     <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      frame_done <= frame_end;
      missed     <= trig && (state != IDLE);
      if (state == IDLE && trig) begin
        addr_q   <= base_addr;
        bit_cnt  <= '0;
        word_cnt <= '0;
      end
      if (rx_vld && state == ADDR) begin
        bit_cnt <= (bit_cnt == 4'd7) ? 4'd0 : bit_cnt + 4'd1;
      end else if (rx_vld && state == DATA) begin
        bit_cnt <= bit_cnt + 4'd1;   // wraps every 16 bits
        rx_sr   <= {rx_sr[WORD_W-3:0], rx_bit};
        if (bit_cnt == 4'd15) begin
          word_valid <= 1'b1;
          word_data  <= {rx_sr, rx_bit};
          word_idx   <= word_cnt;
          word_cnt   <= (word_cnt == IDX_LAST) ? '0 : word_cnt + IDX_W'(1);
        end
      end
      if (frame_end) word_idx <= '0;
    end
  end

`ifdef IMU_TIMESTAMP_EN
  logic [31:0] ts_cnt, ts_lat, ts_out;

  // Captured in the first cs_n-low cycle, published with frame_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt <= '0;
      ts_lat <= '0;
      ts_out <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (state == CS_SETUP && tmr == '0) ts_lat <= ts_cnt;
      if (frame_end) ts_out <= ts_lat;
    end
  end
  assign frame_ts = ts_out;
`else
  assign frame_ts = '0;
`endif

endmodule

// File: tb/tb_imu_autopoll_burst.sv
// Directed bench for imu_autopoll_burst with a MISO model returning 16'h0100+word index.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_imu_autopoll_burst;

  localparam int NUM_REGS = 6;
  localparam int SCK_DIV  = 4;
  localparam int PERIOD_W = 24;
  localparam int IDX_W    = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                autopoll_en;
  logic [PERIOD_W-1:0] poll_period;
  logic                start;
  logic [6:0]          base_addr;
  logic                imu_sck, imu_cs_n, imu_mosi, imu_miso;
  logic                word_valid, frame_done, missed, busy;
  logic [15:0]         word_data;
  logic [IDX_W-1:0]    word_idx;
  logic [31:0]         frame_ts;

  imu_autopoll_burst #(
    .NUM_REGS(NUM_REGS), .SCK_DIV(SCK_DIV), .PERIOD_W(PERIOD_W), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .autopoll_en(autopoll_en), .poll_period(poll_period),
    .start(start), .base_addr(base_addr), .imu_sck(imu_sck), .imu_cs_n(imu_cs_n),
    .imu_mosi(imu_mosi), .imu_miso(imu_miso), .word_valid(word_valid), .word_data(word_data),
    .word_idx(word_idx), .frame_done(frame_done), .missed(missed), .busy(busy),
    .frame_ts(frame_ts)
  );

  initial forever #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, frames = 0, words = 0, missed_cnt = 0, busy_cyc = 0;
  int exp_idx = 0, busy_run = 0, mbit = 0, mosi_n = 0;
  int fd_cyc[$];
  logic [31:0] ts_q[$];
  logic [7:0] mosi_byte;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // IMU model: command bits read as 0, then word k = 16'h0100+k, MSB first, driven on SCK fall.
  initial forever begin
    @(negedge imu_cs_n);
    mbit = 0;
  end
  initial begin
    int k;
    logic [15:0] w;
    imu_miso = 1'b0;
    forever begin
      @(negedge imu_sck);
      if (!imu_cs_n) begin
        if (mbit >= 8) begin
          k = mbit - 8;
          w = 16'h0100 + 16'(k / 16);
          imu_miso = w[15 - (k % 16)];
        end else begin
          imu_miso = 1'b0;
        end
        mbit++;
      end
    end
  end

  // Command byte as seen by the IMU on SCK rising edges.
  initial forever begin
    @(negedge imu_cs_n);
    mosi_n = 0;
    mosi_byte = 8'h00;
  end
  initial forever begin
    @(posedge imu_sck);
    if (!imu_cs_n && mosi_n < 8) begin
      mosi_byte = {mosi_byte[6:0], imu_mosi};
      mosi_n++;
    end
  end

  // Stream monitor: word contents/order, frame completeness, busy continuity.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      exp_idx  = 0;
      busy_run = 0;
    end else begin
      if (word_valid) begin
        chk("word_data", 32'(word_data), 32'h0100 + 32'(exp_idx));
        chk("word_idx", 32'(word_idx), 32'(exp_idx));
        exp_idx++;
        words++;
      end
      if (frame_done) begin
        chk("words_per_frame", 32'(exp_idx), NUM_REGS);
`ifndef IMU_TIMESTAMP_EN
        chk("frame_ts_zero", frame_ts, 32'd0);
`endif
        exp_idx = 0;
        frames++;
        fd_cyc.push_back(cyc);
        ts_q.push_back(frame_ts);
      end
      if (missed) missed_cnt++;
      if (busy) begin
        busy_run++;
        busy_cyc++;
      end else if (busy_run != 0) begin
        // setup 4 + 104 bits * 8 + hold 4 + gap 4
        chk("busy_run_len", 32'(busy_run), 32'd844);
        busy_run = 0;
      end
    end
  end

  initial begin
    int f0, w0, m0, b0, c1, low, bc;
    rst_n = 1'b0; autopoll_en = 1'b0; poll_period = '0; start = 1'b0; base_addr = 7'h2D;
    repeat (3) tick();
    chk("rst_sck", 32'(imu_sck), 1);
    chk("rst_cs_n", 32'(imu_cs_n), 1);
    chk("rst_mosi", 32'(imu_mosi), 0);
    chk("rst_word_valid", 32'(word_valid), 0);
    chk("rst_word_data", 32'(word_data), 0);
    chk("rst_word_idx", 32'(word_idx), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_missed", 32'(missed), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_ts", frame_ts, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Manual poll at 0x2D.
    fd_cyc.delete();
    f0 = frames; w0 = words; m0 = missed_cnt;
    start = 1'b1; tick(); start = 1'b0;
    c1 = cyc;
    chk("cs_fall_latency", 32'(imu_cs_n), 0);
    chk("busy_on", 32'(busy), 1);
    low = 0; bc = 0;
    for (int i = 0; i < 2000 && busy; i++) begin
      if (!imu_cs_n) low++;
      bc++;
      tick();
    end
    // cs_n low over setup + 832 bit cycles + hold; the gap keeps busy 4 more cycles.
    chk("cs_low_cycles", 32'(low), 840);
    chk("busy_cycles", 32'(bc), 844);
    chk("manual_frames", 32'(frames - f0), 1);
    chk("manual_words", 32'(words - w0), 6);
    chk("mosi_cmd", 32'(mosi_byte), 32'hAD);
    chk("manual_missed", 32'(missed_cnt - m0), 0);
    chk("idx_wrapped", 32'(word_idx), 0);
    chk("fd_count_manual", 32'(fd_cyc.size()), 1);
    if (fd_cyc.size() == 1) chk("frame_done_latency", 32'(fd_cyc[0] - c1), 840);

    // Autopoll every 2000 cycles for 10000 cycles.
    fd_cyc.delete(); ts_q.delete();
    f0 = frames; m0 = missed_cnt;
    poll_period = 24'd2000; autopoll_en = 1'b1;
    repeat (10000) tick();
    autopoll_en = 1'b0;
    repeat (1000) tick();
    chk("ap_frames", 32'(frames - f0), 5);
    chk("ap_missed", 32'(missed_cnt - m0), 0);
    chk("ap_fd_count", 32'(fd_cyc.size()), 5);
    for (int i = 1; i < fd_cyc.size(); i++)
      chk("ap_spacing", 32'(fd_cyc[i] - fd_cyc[i-1]), 32'd2000);
`ifdef IMU_TIMESTAMP_EN
    for (int i = 1; i < ts_q.size(); i++)
      chk("ts_spacing", ts_q[i] - ts_q[i-1], 32'd2000);
`endif

    // Overrun: triggers at 500,1000,..,3000 -> frames on odd ones, misses on even ones.
    f0 = frames; m0 = missed_cnt;
    poll_period = 24'd500; autopoll_en = 1'b1;
    repeat (3000) tick();
    autopoll_en = 1'b0;
    repeat (1000) tick();
    chk("ovr_frames", 32'(frames - f0), 3);
    chk("ovr_missed", 32'(missed_cnt - m0), 3);

    // Reset 300 cycles into a burst, during an SCK-low phase.
    f0 = frames;
    start = 1'b1; tick(); start = 1'b0;
    repeat (300) tick();
    chk("pre_rst_sck_low", 32'(imu_sck), 0);
    chk("pre_rst_cs_low", 32'(imu_cs_n), 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_cs_n", 32'(imu_cs_n), 1);
    chk("async_rst_sck", 32'(imu_sck), 1);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_mosi", 32'(imu_mosi), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (1000) tick();
    chk("rst_no_frame_done", 32'(frames - f0), 0);
    w0 = words;
    start = 1'b1; tick(); start = 1'b0;
    repeat (1000) tick();
    chk("post_rst_frames", 32'(frames - f0), 1);
    chk("post_rst_words", 32'(words - w0), 6);

    // poll_period = 0 disables periodic polling; start still works.
    f0 = frames; b0 = busy_cyc;
    poll_period = '0; autopoll_en = 1'b1;
    repeat (5000) tick();
    chk("p0_no_frames", 32'(frames - f0), 0);
    chk("p0_never_busy", 32'(busy_cyc - b0), 0);
    start = 1'b1; tick(); start = 1'b0;
    repeat (1000) tick();
    chk("p0_start_frame", 32'(frames - f0), 1);
    autopoll_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
